// File: rtl/load_value_sequencer.sv
// Preset-table sequencer that drives a loadable up-counter's load/load_value and
// advances on terminal count. Define LOAD_SEQ_LOOP_EN to repeat the table forever.
module load_value_sequencer #(
   parameter int unsigned N     = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [N-1:0]  cfg_data,
   input  logic          start,
   input  logic          abort,
   input  logic [N-1:0]  count,
   output logic          load,
   output logic [N-1:0]  load_value,
   output logic [AW-1:0] seq_index,
   output logic          busy,
   output logic          done
);

   localparam logic [N-1:0]  TERM_COUNT = {N{1'b1}};
   localparam logic [AW-1:0] LAST_INDEX = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state;
   logic [N-1:0]  table_q [DEPTH];
   logic [AW-1:0] next_index;

   assign next_index = seq_index + AW'(1);

   // Preset table: writable in any state, cleared by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            table_q[i] <= '0;
         end
      end else if (cfg_we && (32'(cfg_addr) < DEPTH)) begin
         table_q[cfg_addr] <= cfg_data;
      end
   end

   // Sequencer FSM; load and load_value are set on the edge entering LOAD so the
   // pulse coincides with the LOAD state and reads the table before any same-edge write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         load       <= 1'b0;
         load_value <= '0;
         seq_index  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         load <= 1'b0;
         done <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            seq_index <= '0;
            busy      <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     state      <= S_LOAD;
                     seq_index  <= '0;
                     load       <= 1'b1;
                     load_value <= table_q[0];
                     busy       <= 1'b1;
                  end
               end
               S_LOAD: begin
                  state <= S_RUN;
               end
               S_RUN: begin
                  if (count == TERM_COUNT) begin
                     if (seq_index == LAST_INDEX) begin
                        done <= 1'b1;
`ifdef LOAD_SEQ_LOOP_EN
                        state      <= S_LOAD;
                        seq_index  <= '0;
                        load       <= 1'b1;
                        load_value <= table_q[0];
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
`endif
                     end else begin
                        state      <= S_LOAD;
                        seq_index  <= next_index;
                        load       <= 1'b1;
                        load_value <= table_q[next_index];
                     end
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_load_value_sequencer.sv
// Directed bench for load_value_sequencer with a behavioural 4-bit loadable counter
// closing the count feedback loop.
module tb_load_value_sequencer;

   logic       clk;
   logic       reset;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [3:0] cfg_data;
   logic       start;
   logic       abort;
   logic [3:0] count = '0;
   logic       load;
   logic [3:0] load_value;
   logic [1:0] seq_index;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int lv_q[$];
   int li_q[$];
   int lc_q[$];

   load_value_sequencer #(.N(4), .DEPTH(4), .AW(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .start      (start),
      .abort      (abort),
      .count      (count),
      .load       (load),
      .load_value (load_value),
      .seq_index  (seq_index),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Loadable up-counter model
   always @(posedge clk) begin
      if (load) count <= load_value;
      else      count <= count + 4'd1;
   end

   // Event recorder: load pulses and done pulses with their cycle numbers
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (load === 1'b1) begin
         lv_q.push_back(int'(load_value));
         li_q.push_back(int'(seq_index));
         lc_q.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      lv_q.delete();
      li_q.delete();
      lc_q.delete();
      done_cnt = 0;
   endtask

   task automatic write_entry(input logic [1:0] a, input logic [3:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      check("done_reached", 32'(done === 1'b1), 32'd1);
   endtask

   task automatic wait_load_idx(input int idx, input int budget);
      int k = 0;
      while (!(load === 1'b1 && int'(seq_index) == idx) && k < budget) begin
         tick();
         k++;
      end
      check("load_idx_reached", 32'(load === 1'b1 && int'(seq_index) == idx), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] exp_v [4];
      int         busy_low;
      int         n_loads;

      reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      start = 1'b0; abort = 1'b0;
      tick();
      check("rst_load",       32'(load),       32'd0);
      check("rst_load_value", 32'(load_value), 32'd0);
      check("rst_seq_index",  32'(seq_index),  32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_done",       32'(done),       32'd0);
      tick();
      reset = 1'b1;
      tick();

      // 1: async reset mid-sequence, table lost afterwards
      write_entry(2'd0, 4'd5);
      write_entry(2'd1, 4'd12);
      write_entry(2'd2, 4'd0);
      write_entry(2'd3, 4'd14);
      pulse_start();
      wait_load_idx(1, 100);
      check("t1_pre_value", 32'(load_value), 32'd12);
      check("t1_pre_busy",  32'(busy),       32'd1);
      #2 reset = 1'b0;
      #1;
      check("t1_async_load",  32'(load),       32'd0);
      check("t1_async_value", 32'(load_value), 32'd0);
      check("t1_async_index", 32'(seq_index),  32'd0);
      check("t1_async_busy",  32'(busy),       32'd0);
      check("t1_async_done",  32'(done),       32'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      clear_log();
      pulse_start();
      wait_load_idx(3, 100);
      check("t1_nloads", 32'(lv_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("t1_zero_value", 32'(lv_q[i]), 32'd0);
      pulse_abort();
      tick();

`ifndef LOAD_SEQ_LOOP_EN
      // 2: table {5,12,0,14}, order, entry timing, single done
      write_entry(2'd0, 4'd5);
      write_entry(2'd1, 4'd12);
      write_entry(2'd2, 4'd0);
      write_entry(2'd3, 4'd14);
      exp_v[0] = 4'd5; exp_v[1] = 4'd12; exp_v[2] = 4'd0; exp_v[3] = 4'd14;
      clear_log();
      pulse_start();
      check("t2_start_latency", 32'(load), 32'd1);
      wait_done(200);
      check("t2_done_busy", 32'(busy), 32'd0);
      check("t2_nloads", 32'(lv_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t2_value", 32'(lv_q[i]), 32'(exp_v[i]));
         check("t2_index", 32'(li_q[i]), 32'(i));
      end
      check("t2_entry0_len", 32'(lc_q[1] - lc_q[0]), 32'd12);
      check("t2_entry1_len", 32'(lc_q[2] - lc_q[1]), 32'd5);
      check("t2_entry2_len", 32'(lc_q[3] - lc_q[2]), 32'd17);
      check("t2_entry3_len", 32'(done_cyc - lc_q[3]), 32'd3);
      tick();
      check("t2_done_pulse", 32'(done), 32'd0);
      check("t2_idle_busy",  32'(busy), 32'd0);
      repeat (20) tick();
      check("t2_done_cnt",   32'(done_cnt),    32'd1);
      check("t2_no_reload",  32'(lv_q.size()), 32'd4);

      // 3: all-ones preset lasts LOAD + one RUN cycle
      write_entry(2'd1, 4'd15);
      clear_log();
      pulse_start();
      wait_done(200);
      check("t3_value1",    32'(lv_q[1]),            32'd15);
      check("t3_entry1_len", 32'(lc_q[2] - lc_q[1]), 32'd2);
      check("t3_entry0_len", 32'(lc_q[1] - lc_q[0]), 32'd12);
      check("t3_value2",    32'(lv_q[2]),            32'd0);
      tick();

      // 4: abort in RUN on entry 2, with a simultaneous start
      clear_log();
      pulse_start();
      wait_load_idx(2, 100);
      repeat (3) tick();
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("t4_load",  32'(load),      32'd0);
      check("t4_index", 32'(seq_index), 32'd0);
      check("t4_busy",  32'(busy),      32'd0);
      check("t4_done",  32'(done),      32'd0);
      n_loads = lv_q.size();
      repeat (20) tick();
      check("t4_no_start",   32'(lv_q.size()), 32'(n_loads));
      check("t4_no_done",    32'(done_cnt),    32'd0);
      check("t4_still_idle", 32'(busy),        32'd0);

      // 5: start while busy ignored; write to running entry only affects next pass
      clear_log();
      pulse_start();
      tick();
      tick();
      start    = 1'b1;
      cfg_we   = 1'b1;
      cfg_addr = 2'd0;
      cfg_data = 4'd9;
      tick();
      start  = 1'b0;
      cfg_we = 1'b0;
      wait_done(200);
      exp_v[0] = 4'd5; exp_v[1] = 4'd15; exp_v[2] = 4'd0; exp_v[3] = 4'd14;
      check("t5_nloads", 32'(lv_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("t5_value", 32'(lv_q[i]), 32'(exp_v[i]));
      check("t5_entry0_len", 32'(lc_q[1] - lc_q[0]), 32'd12);
      check("t5_done_cnt", 32'(done_cnt), 32'd1);
      tick();
      pulse_start();
      check("t5_next_load",  32'(load),       32'd1);
      check("t5_next_value", 32'(load_value), 32'd9);
      pulse_abort();
`else
      // 6: looping over {13,14,15,10} for three passes
      write_entry(2'd0, 4'd13);
      write_entry(2'd1, 4'd14);
      write_entry(2'd2, 4'd15);
      write_entry(2'd3, 4'd10);
      exp_v[0] = 4'd13; exp_v[1] = 4'd14; exp_v[2] = 4'd15; exp_v[3] = 4'd10;
      clear_log();
      busy_low = 0;
      pulse_start();
      for (int k = 0; k < 200 && done_cnt < 3; k++) begin
         if (busy !== 1'b1) busy_low++;
         tick();
      end
      check("t6_done_cnt", 32'(done_cnt), 32'd3);
      check("t6_busy_low", 32'(busy_low), 32'd0);
      check("t6_busy_end", 32'(busy),     32'd1);
      check("t6_nloads",   32'(lv_q.size()), 32'd13);
      for (int i = 0; i < 13; i++) begin
         check("t6_value", 32'(lv_q[i]), 32'(exp_v[i % 4]));
         check("t6_index", 32'(li_q[i]), 32'(i % 4));
      end
      check("t6_pass_len",  32'(lc_q[4] - lc_q[0]), 32'd16);
      check("t6_done_wrap", 32'(done_cyc),          32'(lc_q[12]));
      pulse_abort();
      check("t6_abort_busy",  32'(busy),      32'd0);
      check("t6_abort_index", 32'(seq_index), 32'd0);
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
